mac_arbiter: RTL

MAC_ARBITER -- requirements
Module: mac_arbiter

---
 rtl/mac_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mac_arbiter.sv
// Two-requester round-robin arbiter sharing one a*b+m datapath.
// Operands are registered on grant; the result is held until the owner takes it.
module top_level (
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [15:0] M,
  output logic [16:0] RES
);
  logic [15:0] prod;
  assign prod = A * B;
  assign RES  = {1'b0, prod} + {1'b0, M};
endmodule

module mac_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [15:0] req0_m,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [15:0] req1_m,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [16:0] resp_res,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] m_q, m_d;
  logic [16:0] res_q, res_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        gnt0, gnt1;
  logic        own_ready;
  logic [16:0] dp_res;

  top_level u_dp (
    .A   (a_q),
    .B   (b_q),
    .M   (m_q),
    .RES (dp_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      res_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      res_q   <= res_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // On contention the requester not served last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && !rst) begin
      unique case (1'b1)
        (req0_valid && req1_valid): begin
          gnt0 = last_q;
          gnt1 = !last_q;
        end
        (req0_valid && !req1_valid): gnt0 = 1'b1;
        (!req0_valid && req1_valid): gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign own_ready = owner_q ? resp1_ready : resp0_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    res_d   = res_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          a_d     = gnt1 ? req1_a : req0_a;
          b_d     = gnt1 ? req1_b : req0_b;
          m_d     = gnt1 ? req1_m : req0_m;
          owner_d = gnt1;
          state_d = CALC;
        end
      end
      CALC: begin
        res_d   = dp_res;
        state_d = RESP;
      end
      RESP: begin
        if (own_ready) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign resp0_valid = (state_q == RESP) && !owner_q;
  assign resp1_valid = (state_q == RESP) && owner_q;
  assign resp_res    = (state_q == RESP) ? res_q : 17'd0;
  assign busy        = (state_q != IDLE);

endmodule
